sramlike_mem_responder: RTL
===========================

Name: sramlike_mem_responder

Overview:
Responder (slave) end of the SRAM-like request/response bus driven by the CPU's inst/data ports (req/addr_ok then data_ok). Backed by an internal word-addressed memory array with fixed response latency and a bounded in-order queue of outstanding requests. Serves as the simulation/FPGA memory behind either port and is the reference responder for bench handshake checking.

Parameters:
ADDR_WIDTH, 14, word-index bits; memory holds 2^ADDR_WIDTH 32-bit words
LATENCY, 2, cycles from accept to data_ok (legal range 1..15)
MAX_OUTSTANDING, 4, pending-queue depth (power of two, >=2)

Ports:
clk  input  1  clock
resetn  input  1  synchronous active-low reset
req  input  1  request valid
wr  input  1  1 = write, 0 = read
wstrb  input  4  byte enables for writes
addr  input  32  byte address
size  input  3  0 byte, 1 half, 2 word
wdata  input  32  write data
addr_ok  output  1  request accepted this cycle when req && addr_ok
data_ok  output  1  one-cycle response pulse, oldest request first
rdata  output  32  read data, valid only with data_ok

Behaviour:
- Reset: resetn is synchronous, active-low; clock is clk. On reset: queue count 0, all timers 0, data_ok 0, rdata 0, addr_ok 0 during reset cycle. Memory array is not cleared.
- Reset mid-operation discards all outstanding entries; none produces data_ok afterwards.
- Word index = addr[ADDR_WIDTH+1:2]; upper bits ignored (aliasing); addr[1:0] ignored.
- addr_ok = !full (state-only, independent of req). Handshake = req && addr_ok.
- Accept of a write in cycle T: bytes with wstrb[i]=1 written at the T edge; wstrb=0 is a legal no-op write. Entry queued with is_write=1.
- Accept of a read in cycle T: word read at T (reflects all earlier accepted writes), captured into the entry.
- size is not used for datapath; wstrb alone governs writes; reads always return the full word.
- Each entry's timer loads LATENCY-1 at accept and decrements each cycle, saturating at 0.
- data_ok asserts in cycle T+LATENCY for a request accepted at T (head entry, timer 0); entry popped that cycle. Reads: rdata = captured word. Writes: rdata = 0.
- Responses strictly in acceptance order; at most one data_ok per cycle; back-to-back accepts yield back-to-back data_ok when MAX_OUTSTANDING >= LATENCY.
- Full: addr_ok = 0 even if the head retires in the same cycle (no same-cycle bypass). Simultaneous accept and retire when not full: count unchanged.
- Empty: data_ok = 0, rdata holds 0.
- Pointers wrap modulo MAX_OUTSTANDING; count occupies log2(MAX_OUTSTANDING)+1 bits.

Optional Feature:
SRAMLIKE_RAND_STALL_EN: defined -> a 16-bit Fibonacci LFSR (taps 16,14,13,11; seed 16'hACE1 on reset) advances every cycle. addr_ok additionally gated by !lfsr[0]; head retirement additionally gated by !lfsr[1], so data_ok may be delayed beyond LATENCY while order is preserved. Not defined -> no LFSR; timing exactly as above.

Decomposition:
- Shared header common.vh: size encodings (SZ_BYTE/SZ_HALF/SZ_WORD) and LFSR seed constant.
- Sub-module sramlike_pend_fifo: synchronous FIFO of {is_write, rdata, timer}, with push/pop/full/empty and per-entry timer decrement. Top level holds the memory array, handshake and optional LFSR.

Test Plan:
- Write addr 0x100 wdata 0xDEADBEEF wstrb 4'hF, then read 0x100 -> addr_ok each; data_ok at T+2 of each; read rdata 0xDEADBEEF, write response rdata 0.
- Byte write addr 0x104 wstrb 4'b0100 wdata 0x00AB0000 over 0x11223344 -> read returns 0x11AB3344.
- Hold req=1 for 6 reads, LATENCY=2, MAX_OUTSTANDING=4 -> 6 consecutive addr_ok, 6 consecutive data_ok starting 2 cycles after the first accept, in order.
- LATENCY=8, MAX_OUTSTANDING=4, continuous req -> addr_ok drops after 4 accepts, returns the cycle after the first pop; total data_ok count equals accept count.
- Reset asserted with 3 reads outstanding -> no data_ok after reset; post-reset read of a previously written word returns old contents.
- With SRAMLIKE_RAND_STALL_EN, 1000 random reads/writes vs a scoreboard -> all responses in order, data matches, no data_ok with empty queue.

Source files
------------

// File: rtl/sramlike_mem_responder_pkg.sv
// sramlike_mem_responder_pkg: shared size encodings, LFSR seed and pending-entry layout.
package sramlike_mem_responder_pkg;
    localparam logic [2:0] SZ_BYTE = 3'd0;
    localparam logic [2:0] SZ_HALF = 3'd1;
    localparam logic [2:0] SZ_WORD = 3'd2;
    localparam logic [15:0] LFSR_SEED = 16'hACE1;
    localparam int TIMER_W = 4;
    typedef struct packed {
        logic               is_write;
        logic [31:0]        data;
        logic [TIMER_W-1:0] timer;
    } pend_entry_t;
endpackage

// File: rtl/sramlike_mem_responder_pend_fifo.sv
// sramlike_pend_fifo: in-order queue of outstanding requests; every entry's timer
// counts down each cycle and the head is ready once its timer reaches zero.
module sramlike_pend_fifo
    import sramlike_mem_responder_pkg::*;
#(
    parameter int DEPTH   = 4,
    parameter int LATENCY = 2
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        push,
    input  logic        pop,
    input  logic        push_is_write,
    input  logic [31:0] push_data,
    output logic        full,
    output logic        empty,
    output logic        head_ready,
    output logic        head_is_write,
    output logic [31:0] head_data
);
    localparam int PW = $clog2(DEPTH);
    pend_entry_t q [DEPTH];
    logic [PW-1:0] wptr, rptr;
    logic [PW:0] count;
    always_ff @(posedge clk) begin
        if (!resetn) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
            for (int i = 0; i < DEPTH; i++) q[i].timer <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) q[i].timer <= (q[i].timer != '0) ? q[i].timer - 1'b1 : '0;
            if (push) begin
                q[wptr] <= '{is_write: push_is_write, data: push_data, timer: TIMER_W'(LATENCY - 1)};
                wptr    <= wptr + 1'b1;
            end
            if (pop) rptr <= rptr + 1'b1;
            count <= count + (PW+1)'(push) - (PW+1)'(pop);
        end
    end
    assign full          = count == (PW+1)'(DEPTH);
    assign empty         = count == '0;
    assign head_ready    = q[rptr].timer == '0;
    assign head_is_write = q[rptr].is_write;
    assign head_data     = q[rptr].data;
endmodule

// File: rtl/sramlike_mem_responder.sv
// sramlike_mem_responder: SRAM-like bus responder with fixed-latency in-order replies.
// Optional SRAMLIKE_RAND_STALL_EN adds LFSR-driven accept/retire stalls.
module sramlike_mem_responder
    import sramlike_mem_responder_pkg::*;
#(
    parameter int ADDR_WIDTH      = 14,
    parameter int LATENCY         = 2,
    parameter int MAX_OUTSTANDING = 4
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        req,
    input  logic        wr,
    input  logic [3:0]  wstrb,
    input  logic [31:0] addr,
    input  logic [2:0]  size,
    input  logic [31:0] wdata,
    output logic        addr_ok,
    output logic        data_ok,
    output logic [31:0] rdata
);
    logic [31:0] mem [2**ADDR_WIDTH];
    logic [ADDR_WIDTH-1:0] idx;
    logic full, empty, head_ready, head_is_write, accept, pop, can_accept, can_retire, unused;
    logic [31:0] head_data;
    // Upper address bits alias, byte offset and size play no part in the datapath.
    assign unused = ^{addr[31:ADDR_WIDTH+2], addr[1:0], size};
    assign idx    = addr[ADDR_WIDTH+1:2];
`ifdef SRAMLIKE_RAND_STALL_EN
    logic [15:0] lfsr;
    always_ff @(posedge clk) begin
        if (!resetn) lfsr <= LFSR_SEED;
        else lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
    end
    assign can_accept = !lfsr[0];
    assign can_retire = !lfsr[1];
`else
    assign can_accept = 1'b1;
    assign can_retire = 1'b1;
`endif
    // No bypass: a full queue refuses even when the head retires this cycle.
    assign addr_ok = resetn && !full && can_accept;
    assign accept  = req && addr_ok;
    assign pop     = resetn && !empty && head_ready && can_retire;
    assign data_ok = pop;
    assign rdata   = (pop && !head_is_write) ? head_data : '0;
    always_ff @(posedge clk) begin
        if (accept && wr)
            for (int i = 0; i < 4; i++)
                if (wstrb[i]) mem[idx][8*i +: 8] <= wdata[8*i +: 8];
    end
    sramlike_pend_fifo #(.DEPTH(MAX_OUTSTANDING), .LATENCY(LATENCY)) u_fifo (
        .clk          (clk),
        .resetn       (resetn),
        .push         (accept),
        .pop          (pop),
        .push_is_write(wr),
        .push_data    (wr ? 32'h0 : mem[idx]),
        .full         (full),
        .empty        (empty),
        .head_ready   (head_ready),
        .head_is_write(head_is_write),
        .head_data    (head_data)
    );
endmodule
